rti_control: RTL and testbench

RTI_CONTROL -- requirements
Module: rti_control

---
 rtl/rti_pkg.sv | 39 +++
 rtl/rti_if.sv | 13 +
 rtl/rti_wait_counter.sv | 26 ++
 rtl/rti_control.sv | 125 ++++++++++++
 tb/tb_rti_control.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rti_pkg.sv
// Shared RTI sequencer definitions: state encoding, datapath control codes and
// counter widths, so the datapath decoder and the sequencer agree on values.
package rti_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_STALL     = 3'd1,
    ST_POP_FLAGS = 3'd2,
    ST_POP_PC_H  = 3'd3,
    ST_POP_PC_L  = 3'd4,
    ST_FLUSH     = 3'd5
  } rti_state_t;

  localparam logic [3:0] OUT_IDLE      = 4'b0000;
  localparam logic [3:0] OUT_STALL     = 4'b0001;
  localparam logic [3:0] OUT_POP_FLAGS = 4'b0011;
  localparam logic [3:0] OUT_POP_PC_H  = 4'b0101;
  localparam logic [3:0] OUT_POP_PC_L  = 4'b0111;
  localparam logic [3:0] OUT_FLUSH     = 4'b1000;

  localparam int STALL_CNT_W = 4;
  localparam int WAIT_CNT_W  = 8;

  function automatic logic [3:0] state_out(input rti_state_t s);
    logic [3:0] code;
    code = OUT_IDLE;
    case (s)
      ST_IDLE:      code = OUT_IDLE;
      ST_STALL:     code = OUT_STALL;
      ST_POP_FLAGS: code = OUT_POP_FLAGS;
      ST_POP_PC_H:  code = OUT_POP_PC_H;
      ST_POP_PC_L:  code = OUT_POP_PC_L;
      ST_FLUSH:     code = OUT_FLUSH;
      default:      code = OUT_IDLE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/rti_if.sv
// Decode/datapath-side signal bundle of the RTI sequencer.
// slave = sequencer side, master = decode stage / datapath side.
interface rti_if;
  logic       rtiSignal;
  logic       memReady;
  logic [3:0] out;
  logic       busy;
  logic       done;
  logic       err;

  modport master (output rtiSignal, memReady, input out, busy, done, err);
  modport slave  (input rtiSignal, memReady, output out, busy, done, err);
endinterface

// File: rtl/rti_wait_counter.sv
// Loadable down-counter with terminal-count flag; shared by the stall phase
// and the per-pop memory timeout.
module rti_wait_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  input  logic             i_enable,
  output logic             o_tc
);
  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_value;
    end else if (i_enable && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_tc = (r_count == '0);
endmodule

// File: rtl/rti_control.sv
// RTI return sequencer: stall, pop FLAGS/PC_H/PC_L from the stack, flush.
// Optional macro RTI_FLAGS_EN keeps the POP_FLAGS phase; undefined removes it.
module rti_control
  import rti_pkg::*;
#(
  parameter int STALL_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 8
) (
  input  logic clk,
  input  logic rst,
  rti_if.slave bus
);
  localparam logic [STALL_CNT_W-1:0] STALL_LOAD = STALL_CNT_W'(STALL_CYCLES - 1);
  localparam logic [WAIT_CNT_W-1:0]  WAIT_LOAD  = WAIT_CNT_W'(MEM_TIMEOUT - 1);

  rti_state_t r_state;
  rti_state_t w_state_next;
  logic       r_rti_prev;
  logic [3:0] r_out;
  logic       r_done;
  logic       r_err;
  logic       w_rti_edge;
  logic       w_timeout;
  logic       w_in_pop;
  logic       w_stall_load;
  logic       w_stall_en;
  logic       w_stall_tc;
  logic       w_wait_load;
  logic       w_wait_en;
  logic       w_wait_tc;

  // Edge history runs in every state, so edges seen while busy are simply lost.
  assign w_rti_edge = bus.rtiSignal & ~r_rti_prev;
  assign w_in_pop   = r_state inside {ST_POP_FLAGS, ST_POP_PC_H, ST_POP_PC_L};

  always_comb begin
    w_state_next = r_state;
    w_timeout    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rti_edge) w_state_next = ST_STALL;
      end
      ST_STALL: begin
`ifdef RTI_FLAGS_EN
        if (w_stall_tc) w_state_next = ST_POP_FLAGS;
`else
        if (w_stall_tc) w_state_next = ST_POP_PC_H;
`endif
      end
`ifdef RTI_FLAGS_EN
      ST_POP_FLAGS: begin
        if (bus.memReady) begin
          w_state_next = ST_POP_PC_H;
        end else if (w_wait_tc) begin
          w_state_next = ST_FLUSH;
          w_timeout    = 1'b1;
        end
      end
`endif
      ST_POP_PC_H: begin
        if (bus.memReady) begin
          w_state_next = ST_POP_PC_L;
        end else if (w_wait_tc) begin
          w_state_next = ST_FLUSH;
          w_timeout    = 1'b1;
        end
      end
      ST_POP_PC_L: begin
        if (bus.memReady) begin
          w_state_next = ST_FLUSH;
        end else if (w_wait_tc) begin
          w_state_next = ST_FLUSH;
          w_timeout    = 1'b1;
        end
      end
      ST_FLUSH: w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  assign w_stall_load = (r_state == ST_IDLE) && w_rti_edge;
  assign w_stall_en   = (r_state == ST_STALL);
  // Reloading on every state change gives each pop its own full timeout window.
  assign w_wait_load  = (w_state_next != r_state);
  assign w_wait_en    = w_in_pop && !bus.memReady;

  rti_wait_counter #(.WIDTH(STALL_CNT_W)) u_stall_cnt (
    .clk          (clk),
    .rst          (rst),
    .i_load       (w_stall_load),
    .i_load_value (STALL_LOAD),
    .i_enable     (w_stall_en),
    .o_tc         (w_stall_tc)
  );

  rti_wait_counter #(.WIDTH(WAIT_CNT_W)) u_wait_cnt (
    .clk          (clk),
    .rst          (rst),
    .i_load       (w_wait_load),
    .i_load_value (WAIT_LOAD),
    .i_enable     (w_wait_en),
    .o_tc         (w_wait_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_rti_prev <= 1'b0;
      r_out      <= OUT_IDLE;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_rti_prev <= bus.rtiSignal;
      r_out      <= state_out(w_state_next);
      r_done     <= (r_state == ST_FLUSH);
      if (w_timeout) r_err <= 1'b1;
    end
  end

  assign bus.out  = r_out;
  assign bus.busy = (r_state != ST_IDLE);
  assign bus.done = r_done;
  assign bus.err  = r_err;
endmodule

// File: tb/tb_rti_control.sv
// Scoreboard bench for rti_control: a sequence-level reference model turns the
// per-cycle stimulus into expected outputs, a negedge monitor compares them.
`timescale 1ns/1ps
module tb_rti_control;
  localparam int S    = 2;
  localparam int T    = 8;
  localparam int MAXC = 1024;
`ifdef RTI_FLAGS_EN
  localparam int NPH = 3;
`else
  localparam int NPH = 2;
`endif

  typedef struct packed {
    logic [3:0] out;
    logic       busy;
    logic       done;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  rti_if bus ();

  rti_control #(.STALL_CYCLES(S), .MEM_TIMEOUT(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t  exp_q[$];
  int    idx_q[$];
  bit    rti_v [MAXC];
  bit    mem_v [MAXC];
  exp_t  exp_v [MAXC];
  int    errors = 0;
  int    checks = 0;
  int    seqs   = 0;
  string seg_name = "reset";

  task automatic check(input string name, input logic [6:0] got, input logic [6:0] want, input int cyc);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cycle %0d: got {out,busy,done,err}=%b required=%b", name, cyc, got, want);
    end
  endtask

  // Control codes of the pop phases in order of occurrence.
  function automatic logic [3:0] pop_code(input int ph);
    logic [3:0] c;
    c = 4'b0000;
    if (NPH == 3) begin
      case (ph)
        0: c = 4'b0011;
        1: c = 4'b0101;
        default: c = 4'b0111;
      endcase
    end else begin
      case (ph)
        0: c = 4'b0101;
        default: c = 4'b0111;
      endcase
    end
    return c;
  endfunction

  function automatic void put(input int i, input logic [3:0] code);
    if (i < MAXC) exp_v[i].out = code;
  endfunction

  // Cycle j observes outputs after the edge that sampled inputs of cycle j-1.
  task automatic build_model(input int len);
    int s, c, hit, err_at;
    bit to;
    for (int j = 0; j < MAXC; j++) exp_v[j] = '0;
    err_at = MAXC;
    s = 0;
    while (s < len) begin
      if (rti_v[s] && (s == 0 || !rti_v[s-1])) begin
        c = s + 1;
        for (int k = 0; k < S; k++) put(c + k, 4'b0001);
        c += S;
        to = 1'b0;
        for (int ph = 0; ph < NPH && !to; ph++) begin
          hit = -1;
          for (int w = 0; w < T; w++) if (hit < 0 && (c + w) < MAXC && mem_v[c+w]) hit = w;
          if (hit < 0) begin
            for (int w = 0; w < T; w++) put(c + w, pop_code(ph));
            c += T;
            to = 1'b1;
            if (c < err_at) err_at = c;
          end else begin
            for (int w = 0; w <= hit; w++) put(c + w, pop_code(ph));
            c += hit + 1;
          end
        end
        put(c, 4'b1000);
        if (c + 1 < MAXC) exp_v[c+1].done = 1'b1;
        s = c + 1;
      end else begin
        s++;
      end
    end
    for (int j = 0; j < MAXC; j++) begin
      exp_v[j].err  = (j >= err_at);
      exp_v[j].busy = (exp_v[j].out != 4'b0000);
    end
  endtask

  task automatic clear_stim();
    for (int j = 0; j < MAXC; j++) begin
      rti_v[j] = 1'b0;
      mem_v[j] = 1'b0;
    end
  endtask

  task automatic apply_reset(input int n);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.rtiSignal = 1'b0;
    bus.memReady  = 1'b0;
    #1;
    check("rst_async", {bus.out, bus.busy, bus.done, bus.err}, 7'b0, 0);
    repeat (n) @(posedge clk);
  endtask

  // Releases reset and drives one stimulus cycle per clock, pushing expectations.
  task automatic run_seg(input string name, input int len);
    seg_name = name;
    build_model(len);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int j = 0; j < len; j++) begin
      if (j > 0) begin
        @(posedge clk);
        #1;
      end
      bus.rtiSignal = rti_v[j];
      bus.memReady  = mem_v[j];
      exp_q.push_back(exp_v[j]);
      idx_q.push_back(j);
    end
    for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(posedge clk);
    if (exp_q.size() > 0) begin
      check("drain", 7'(exp_q.size()), 7'b0, len);
      exp_q.delete();
      idx_q.delete();
    end
  endtask

  initial begin : monitor
    exp_t e;
    int   j;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        j = idx_q.pop_front();
        check(seg_name, {bus.out, bus.busy, bus.done, bus.err}, e, j);
        if (e.done) begin
          seqs++;
          $display("seq %0d done in %s at cycle %0d err=%b", seqs, seg_name, j, e.err);
        end
      end
    end
  end

  initial begin : stimulus
    int  ph_start, pth;
    bit  found, done_seen;
    bus.rtiSignal = 1'b0;
    bus.memReady  = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check("reset_state", {bus.out, bus.busy, bus.done, bus.err}, 7'b0, 0);

    // Nominal sequence, level held across done, then a fresh low-high toggle.
    clear_stim();
    for (int j = 0; j < MAXC; j++) begin
      rti_v[j] = (j >= 2 && j < 20) || (j >= 23);
      mem_v[j] = 1'b1;
    end
    run_seg("nominal", 40);

    // memReady low for three cycles at the start of POP_PC_H.
    apply_reset(3);
    clear_stim();
    ph_start = 2 + S + (NPH - 2);
    for (int j = 0; j < MAXC; j++) begin
      rti_v[j] = (j >= 1);
      mem_v[j] = !(j >= ph_start && j < ph_start + 3);
    end
    run_seg("pc_h_wait", 30);

    // memReady never high: timeout, sticky err across a second sequence.
    apply_reset(3);
    clear_stim();
    for (int j = 0; j < MAXC; j++) rti_v[j] = (j < 15) || (j >= 18);
    run_seg("timeout", 50);

    for (int r = 0; r < 6; r++) begin
      apply_reset(2);
      clear_stim();
      pth = (r * 3 + 1) % 8 + 1;
      rti_v[0] = 1'($urandom_range(0, 1));
      for (int j = 1; j < MAXC; j++) begin
        rti_v[j] = ($urandom_range(0, 5) == 0) ? !rti_v[j-1] : rti_v[j-1];
        mem_v[j] = ($urandom_range(0, 7) < pth);
      end
      mem_v[0] = ($urandom_range(0, 7) < pth);
      run_seg($sformatf("random%0d", r), 300);
    end

    // Asynchronous reset while in POP_PC_L: no done afterwards.
    apply_reset(3);
    seg_name = "rst_mid";
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.rtiSignal = 1'b1;
    bus.memReady  = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(posedge clk);
      #1;
      if (bus.out == 4'b0111) found = 1'b1;
    end
    check("reach_pop_pc_l", {6'b0, found}, 7'b1, 0);
    bus.memReady = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_async", {bus.out, bus.busy, bus.done, bus.err}, 7'b0, 0);
    bus.rtiSignal = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    done_seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done || bus.busy) done_seen = 1'b1;
    end
    check("no_done_after_rst", {6'b0, done_seen}, 7'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
